// File: rtl/hue_stage1.sv
// hue_stage1: back end of the hue pipeline.
// Holds a 3-bit tag {zero_flag, function} per pixel while it is inside the
// divider, pairs each returning quotient with its tag and turns the quotient
// into integer hue degrees 0..359, flagging grey pixels.
//
// Tag FIFO rules worth remembering:
//   - a push while full is accepted only if a pop happens the same cycle;
//   - a result arriving while empty is dropped, even if a tag is pushed in
//     that same cycle (no bypass path from push to pop).
module hue_stage1 #(
    parameter int FRAC_W    = 8,
    parameter int TAG_DEPTH = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_tag_valid,
    input  logic [1:0]                   i_tag_function,
    input  logic [8:0]                   i_tag_divisor,
    input  logic                         i_div_valid,
    input  logic [FRAC_W+1:0]            i_div_quotient,
    output logic                         o_valid,
    output logic [8:0]                   o_hue,
    output logic                         o_achromatic,
    output logic [$clog2(TAG_DEPTH):0]   o_tag_level,
    output logic                         o_err_overflow,
    output logic                         o_err_underflow
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int P_W   = FRAC_W + 8;

    localparam logic signed [P_W-1:0] MUL60  = P_W'(60);
    localparam logic signed [P_W-1:0] RND    = P_W'(1) << (FRAC_W - 1);
    localparam logic signed [P_W-1:0] DEG120 = P_W'(120);
    localparam logic signed [P_W-1:0] DEG240 = P_W'(240);
    localparam logic signed [P_W-1:0] DEG360 = P_W'(360);

    logic [2:0]             tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   do_push;
    logic                   do_pop;
    logic [2:0]             tag_in;

    logic signed [P_W-1:0]  prod_c;
    logic                   a_valid;
    logic signed [P_W-1:0]  a_prod;
    logic [2:0]             a_tag;

    logic signed [P_W-1:0]  offset;
    logic signed [P_W-1:0]  rnd_sum;
    logic signed [P_W-1:0]  rounded;
    logic signed [P_W-1:0]  h_raw;
    logic signed [P_W-1:0]  h_wrap;
    logic                   achro_c;

    assign fifo_full  = (o_tag_level == LVL_W'(TAG_DEPTH));
    assign fifo_empty = (o_tag_level == '0);
    assign do_pop     = i_div_valid & ~fifo_empty;
    assign do_push    = i_tag_valid & (~fifo_full | do_pop);
    assign tag_in     = {(i_tag_divisor == 9'd0), i_tag_function};

    // Sign-extend the Q2.FRAC_W quotient and scale by 60 degrees per unit.
    assign prod_c = $signed({{6{i_div_quotient[FRAC_W+1]}}, i_div_quotient}) * MUL60;

    // Tag storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge i_clk) begin
        if (!i_rst && do_push) begin
            tag_mem[wr_ptr] <= tag_in;
        end
    end

    // FIFO pointers, occupancy and sticky error flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            o_tag_level     <= '0;
            o_err_overflow  <= 1'b0;
            o_err_underflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            o_tag_level <= o_tag_level + LVL_W'(do_push) - LVL_W'(do_pop);
            if (i_tag_valid && fifo_full && !do_pop) begin
                o_err_overflow <= 1'b1;
            end
            if (i_div_valid && fifo_empty) begin
                o_err_underflow <= 1'b1;
            end
        end
    end

    // Stage A: register the scaled quotient with its popped tag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_valid <= 1'b0;
            a_prod  <= '0;
            a_tag   <= '0;
        end else begin
            a_valid <= do_pop;
            if (do_pop) begin
                a_prod <= prod_c;
                a_tag  <= tag_mem[rd_ptr];
            end
        end
    end

    // Stage B arithmetic: round half up, add sector offset, fold into 0..359.
    always_comb begin
        offset = '0;
        case (a_tag[1:0])
            2'd2:    offset = DEG120;
            2'd3:    offset = DEG240;
            default: offset = '0;
        endcase
        rnd_sum = a_prod + RND;
        rounded = rnd_sum >>> FRAC_W;
        h_raw   = rounded + offset;
        if (h_raw[P_W-1]) begin
            h_wrap = h_raw + DEG360;
        end else if (h_raw >= DEG360) begin
            h_wrap = h_raw - DEG360;
        end else begin
            h_wrap = h_raw;
        end
        // Zero divisor means max==min; function 0 is never produced by a real pixel.
        achro_c = a_tag[2] | (a_tag[1:0] == 2'd0);
    end

    // Stage B register: outputs hold between valid pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid      <= 1'b0;
            o_hue        <= '0;
            o_achromatic <= 1'b0;
        end else begin
            o_valid <= a_valid;
            if (a_valid) begin
                o_achromatic <= achro_c;
                o_hue        <= achro_c ? 9'd0 : 9'(h_wrap);
            end
        end
    end

endmodule

// File: tb/tb_hue_stage1.sv
// tb_hue_stage1: scoreboard bench for hue_stage1 (FRAC_W=8, TAG_DEPTH=32).
module tb_hue_stage1;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_tag_valid = 1'b0;
    logic [1:0] i_tag_function = '0;
    logic [8:0] i_tag_divisor = '0;
    logic       i_div_valid = 1'b0;
    logic [9:0] i_div_quotient = '0;
    logic       o_valid;
    logic [8:0] o_hue;
    logic       o_achromatic;
    logic [5:0] o_tag_level;
    logic       o_err_overflow;
    logic       o_err_underflow;

    hue_stage1 #(.FRAC_W(8), .TAG_DEPTH(32)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_tag_valid    (i_tag_valid),
        .i_tag_function (i_tag_function),
        .i_tag_divisor  (i_tag_divisor),
        .i_div_valid    (i_div_valid),
        .i_div_quotient (i_div_quotient),
        .o_valid        (o_valid),
        .o_hue          (o_hue),
        .o_achromatic   (o_achromatic),
        .o_tag_level    (o_tag_level),
        .o_err_overflow (o_err_overflow),
        .o_err_underflow(o_err_underflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int due;
        int hue;
        int ach;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] tag_q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_mis = 0;
    logic       exp_ovf = 1'b0;
    logic       exp_unf = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference hue for a tag and a raw Q2.8 quotient; returns {hue, achromatic}.
    function automatic logic [9:0] hue_model(input logic [2:0] t, input int q);
        int prod, r, h;
        if (t[2] || t[1:0] == 2'd0) return 10'b1;
        prod = q * 60;
        r    = (prod + 128) >>> 8;
        h    = r + (int'(t[1:0]) - 1) * 120;
        if (h < 0) h += 360;
        else if (h >= 360) h -= 360;
        return {9'(h), 1'b0};
    endfunction

    // Output monitor: every o_valid pulse must match the oldest expectation, on time.
    always @(negedge i_clk) begin
        if (o_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", cyc, e.due);
                chk("hue", int'(o_hue), e.hue);
                chk("achromatic", int'(o_achromatic), e.ach);
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drive one cycle; eh >= 0 supplies a hand-derived expected hue/achromatic.
    task automatic step(input logic tv, input logic [1:0] fn, input logic [8:0] dvs,
                        input logic rv, input int q, input int eh = -1, input int ea = 0);
        logic       pop_ok, push_ok;
        logic [2:0] t;
        logic [9:0] m;
        exp_t       e;
        i_tag_valid    = tv;
        i_tag_function = fn;
        i_tag_divisor  = dvs;
        i_div_valid    = rv;
        i_div_quotient = 10'(q);
        pop_ok  = rv && (tag_q.size() > 0);
        push_ok = tv && ((tag_q.size() < 32) || pop_ok);
        if (pop_ok) begin
            t     = tag_q.pop_front();
            m     = hue_model(t, q);
            e.due = cyc + 2;
            e.hue = (eh >= 0) ? eh : int'(m[9:1]);
            e.ach = (eh >= 0) ? ea : int'(m[0]);
            sb.push_back(e);
        end
        if (rv && !pop_ok) exp_unf = 1'b1;
        if (tv && !push_ok) exp_ovf = 1'b1;
        if (push_ok) tag_q.push_back({(dvs == 9'd0), fn});
        tick();
        i_tag_valid = 1'b0;
        i_div_valid = 1'b0;
        chk("tag_level", int'(o_tag_level), tag_q.size());
        chk("err_overflow", int'(o_err_overflow), int'(exp_ovf));
        chk("err_underflow", int'(o_err_underflow), int'(exp_unf));
    endtask

    task automatic idle(input int n);
        i_tag_valid = 1'b0;
        i_div_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Reset takes effect at the next edge: outputs due after it are dropped.
    task automatic rst_pulse(input int n);
        i_rst       = 1'b1;
        i_tag_valid = 1'b0;
        i_div_valid = 1'b0;
        while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
        tag_q.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        repeat (n) tick();
        i_rst = 1'b0;
    endtask

    task automatic chk_clear(input string tag);
        chk({tag, "_valid"}, int'(o_valid), 0);
        chk({tag, "_level"}, int'(o_tag_level), 0);
        chk({tag, "_ovf"}, int'(o_err_overflow), 0);
        chk({tag, "_unf"}, int'(o_err_underflow), 0);
    endtask

    initial begin
        int guard;
        tick();
        rst_pulse(2);
        chk_clear("reset");
        chk("reset_hue", int'(o_hue), 0);
        chk("reset_achromatic", int'(o_achromatic), 0);

        // Primary colours
        step(1, 2'd1, 9'd248, 0, 0);
        step(1, 2'd2, 9'd252, 0, 0);
        step(1, 2'd3, 9'd248, 0, 0);
        step(0, 2'd0, 9'd0, 1, 0, 0, 0);
        step(0, 2'd0, 9'd0, 1, 0, 120, 0);
        step(0, 2'd0, 9'd0, 1, 0, 240, 0);
        idle(2);
        chk("hold_hue", int'(o_hue), 240);
        chk("hold_valid", int'(o_valid), 0);

        // Negative wrap
        repeat (3) step(1, 2'd1, 9'd248, 0, 0);
        step(0, 2'd0, 9'd0, 1, -256, 300, 0);
        step(0, 2'd0, 9'd0, 1, -2, 0, 0);
        step(0, 2'd0, 9'd0, 1, -3, 359, 0);
        idle(3);

        // Fractional rounding
        step(1, 2'd1, 9'd10, 0, 0);
        step(1, 2'd2, 9'd10, 0, 0);
        step(1, 2'd3, 9'd10, 0, 0);
        step(0, 2'd0, 9'd0, 1, 128, 30, 0);
        step(0, 2'd0, 9'd0, 1, -128, 90, 0);
        step(0, 2'd0, 9'd0, 1, 256, 300, 0);
        idle(3);

        // Grey pixel and function code 0
        step(1, 2'd1, 9'd0, 0, 0);
        step(1, 2'd0, 9'd5, 0, 0);
        step(0, 2'd0, 9'd0, 1, 'h155, 0, 1);
        step(0, 2'd0, 9'd0, 1, 40, 0, 1);
        idle(3);

        // FIFO limits: 33 pushes, then 33 results
        for (int i = 0; i < 33; i++) step(1, 2'(1 + i % 3), 9'(i), 0, 0);
        for (int i = 0; i < 33; i++) step(0, 2'd0, 9'd0, 1, i * 7 - 100);
        idle(3);
        chk("drain_level", int'(o_tag_level), 0);

        // Reset mid-stream with two results in flight
        rst_pulse(1);
        for (int i = 0; i < 5; i++) step(1, 2'd2, 9'(20 + i), 0, 0);
        step(0, 2'd0, 9'd0, 1, 30);
        step(0, 2'd0, 9'd0, 1, 60);
        rst_pulse(1);
        idle(4);
        chk_clear("midreset");
        step(1, 2'd2, 9'd50, 0, 0);
        step(0, 2'd0, 9'd0, 1, 64, 135, 0);
        idle(3);

        // Full FIFO with simultaneous push and pop, then back-to-back drain
        for (int i = 0; i < 32; i++) step(1, 2'(1 + i % 3), 9'(i + 1), 0, 0);
        step(1, 2'd3, 9'd77, 1, 100);
        chk("full_pushpop_ovf", int'(o_err_overflow), 0);
        for (int i = 0; i < 32; i++) step(0, 2'd0, 9'd0, 1, 255 - i * 16);
        idle(3);

        // Result on empty FIFO with same-cycle push: no bypass
        step(1, 2'd1, 9'd10, 1, 50);
        chk("nobypass_level", int'(o_tag_level), 1);

        // Mixed random traffic
        for (int i = 0; i < 80; i++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 9'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 511)),
                 1'($urandom_range(0, 9) < 5), $urandom_range(0, 512) - 256);
        guard = 0;
        while (tag_q.size() > 0 && guard < 64) begin
            step(0, 2'd0, 9'd0, 1, $urandom_range(0, 512) - 256);
            guard++;
        end
        idle(4);
        chk("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
